// File: rtl/irq_controller_if.sv
// Interrupt controller <-> CPU/peripheral bundle.
//   master : drives requests, CPU handshake (cpu_busy, int_ack, eoi) and mask writes
//   slave  : the controller; drives int_req, int_vector, int_id, in_service, nmi_active, mask
interface irq_controller_if #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = 3
);
  logic [NUM_IRQ-1:0] irq;
  logic               nmi;
  logic               cpu_busy;
  logic               int_ack;
  logic               eoi;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               int_req;
  logic [31:0]        int_vector;
  logic [ID_W-1:0]    int_id;
  logic               in_service;
  logic               nmi_active;
  logic [NUM_IRQ-1:0] mask;

  modport master (
    output irq, nmi, cpu_busy, int_ack, eoi, mask_we, mask_wdata,
    input  int_req, int_vector, int_id, in_service, nmi_active, mask
  );

  modport slave (
    input  irq, nmi, cpu_busy, int_ack, eoi, mask_we, mask_wdata,
    output int_req, int_vector, int_id, in_service, nmi_active, mask
  );
endinterface

// File: rtl/irq_controller.sv
// Prioritised, maskable interrupt controller with one NMI, fronting the multi-cycle MIPS core.
// Presents one request at a time (int_req + int_vector + int_id), handshakes through
// cpu_busy / int_ack / eoi, and allows one level of NMI preemption over a maskable handler.
//
// Ports:
//   clock  - system clock, all state on its rising edge
//   reset  - synchronous, active-high
//   bus    - irq_controller_if.slave: irq, nmi, cpu_busy, int_ack, eoi, mask_we, mask_wdata in;
//            int_req, int_vector, int_id, in_service, nmi_active, mask out
//
// Build option: define IRQ_LEVEL_EN for level-sensitive irq lines (no pend latch; a request
// withdrawn before ack abandons the presentation). NMI is always edge-sensitive.
module irq_controller #(
  parameter int unsigned NUM_IRQ    = 8,
  parameter int unsigned ID_W       = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter int unsigned VEC_STRIDE = 8,
  parameter logic [31:0] NMI_VECTOR = 32'h0000_0080
) (
  input logic            clock,
  input logic            reset,
  irq_controller_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StReq, StServ, StNreq, StNserv} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] eligible;
  logic               nmi_prev_q, nmi_pend_q, nmi_pend_d;
  logic               int_req_q, int_req_d;
  logic [31:0]        int_vector_q, int_vector_d;
  logic [ID_W-1:0]    int_id_q, int_id_d;
  logic               in_service_q, in_service_d;
  logic               nmi_active_q, nmi_active_d;
  logic [ID_W-1:0]    saved_id_q, saved_id_d;
  logic [31:0]        saved_vec_q, saved_vec_d;
  logic               win_any;
  logic [ID_W-1:0]    win_id;
  logic [31:0]        win_vec;

`ifdef IRQ_LEVEL_EN
  // Level mode: the live line is the request; cur_eligible tracks the presented channel.
  logic cur_eligible;

  assign eligible = bus.irq & ~mask_q;

  always_comb begin
    cur_eligible = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (int_id_q == ID_W'(i)) cur_eligible = eligible[i];
    end
  end
`else
  logic [NUM_IRQ-1:0] pend_q, pend_d, irq_prev_q, pend_clr;

  // A new edge on the channel being acked wins over the clear: it is a fresh request.
  always_comb begin
    pend_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      pend_clr[i] = (state_q == StReq) && bus.int_ack && (int_id_q == ID_W'(i));
    end
    pend_d = (pend_q & ~pend_clr) | (bus.irq & ~irq_prev_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q     <= '0;
      irq_prev_q <= '0;
    end else begin
      pend_q     <= pend_d;
      irq_prev_q <= bus.irq;
    end
  end

  assign eligible = pend_q & ~mask_q;
`endif

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    win_any = 1'b0;
    win_id  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_any = 1'b1;
        win_id  = ID_W'(i);
      end
    end
  end

  assign win_vec = VEC_BASE + (32'(win_id) * VEC_STRIDE);

  assign nmi_pend_d = (nmi_pend_q & ~((state_q == StNreq) && bus.int_ack))
                    | (bus.nmi & ~nmi_prev_q);

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    int_vector_d = int_vector_q;
    int_id_d     = int_id_q;
    in_service_d = in_service_q;
    nmi_active_d = nmi_active_q;
    saved_id_d   = saved_id_q;
    saved_vec_d  = saved_vec_q;
    unique case (state_q)
      StIdle: begin
        if (nmi_pend_q && !bus.cpu_busy) begin
          state_d      = StNreq;
          int_req_d    = 1'b1;
          int_vector_d = NMI_VECTOR;
          int_id_d     = '0;
        end else if (win_any && !bus.cpu_busy) begin
          state_d      = StReq;
          int_req_d    = 1'b1;
          int_vector_d = win_vec;
          int_id_d     = win_id;
        end
      end
      StReq: begin
        // Ack has priority over a concurrent NMI; the NMI then preempts from StServ.
        if (bus.int_ack) begin
          state_d      = StServ;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
        end else if (nmi_pend_q) begin
          state_d      = StNreq;
          int_vector_d = NMI_VECTOR;
          int_id_d     = '0;
        end
`ifdef IRQ_LEVEL_EN
        else if (!cur_eligible) begin
          state_d      = StIdle;
          int_req_d    = 1'b0;
          int_vector_d = '0;
          int_id_d     = '0;
        end
`endif
      end
      StServ: begin
        if (bus.eoi) begin
          state_d      = StIdle;
          in_service_d = 1'b0;
          int_vector_d = '0;
          int_id_d     = '0;
        end else if (nmi_pend_q && !bus.cpu_busy) begin
          state_d      = StNreq;
          int_req_d    = 1'b1;
          saved_id_d   = int_id_q;
          saved_vec_d  = int_vector_q;
          int_vector_d = NMI_VECTOR;
          int_id_d     = '0;
        end
      end
      StNreq: begin
        if (bus.int_ack) begin
          state_d      = StNserv;
          int_req_d    = 1'b0;
          nmi_active_d = 1'b1;
        end
      end
      StNserv: begin
        // in_service still set means the NMI preempted a maskable handler.
        if (bus.eoi) begin
          nmi_active_d = 1'b0;
          if (in_service_q) begin
            state_d      = StServ;
            int_vector_d = saved_vec_q;
            int_id_d     = saved_id_q;
          end else begin
            state_d      = StIdle;
            int_vector_d = '0;
            int_id_d     = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      mask_q       <= '1;
      nmi_prev_q   <= 1'b0;
      nmi_pend_q   <= 1'b0;
      int_req_q    <= 1'b0;
      int_vector_q <= '0;
      int_id_q     <= '0;
      in_service_q <= 1'b0;
      nmi_active_q <= 1'b0;
      saved_id_q   <= '0;
      saved_vec_q  <= '0;
    end else begin
      state_q      <= state_d;
      if (bus.mask_we) mask_q <= bus.mask_wdata;
      nmi_prev_q   <= bus.nmi;
      nmi_pend_q   <= nmi_pend_d;
      int_req_q    <= int_req_d;
      int_vector_q <= int_vector_d;
      int_id_q     <= int_id_d;
      in_service_q <= in_service_d;
      nmi_active_q <= nmi_active_d;
      saved_id_q   <= saved_id_d;
      saved_vec_q  <= saved_vec_d;
    end
  end

  assign bus.int_req    = int_req_q;
  assign bus.int_vector = int_vector_q;
  assign bus.int_id     = int_id_q;
  assign bus.in_service = in_service_q;
  assign bus.nmi_active = nmi_active_q;
  assign bus.mask       = mask_q;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller with a scoreboard of expected presentations
// (id, vector) pushed when a request is driven and popped when int_req appears.
module tb_irq_controller;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  typedef struct packed {
    logic [2:0]  id;
    logic [31:0] vec;
  } exp_t;

  exp_t sb[$];

  irq_controller_if #(.NUM_IRQ(8), .ID_W(3)) bus ();

  irq_controller #(
    .NUM_IRQ   (8),
    .ID_W      (3),
    .VEC_BASE  (32'h0000_0100),
    .VEC_STRIDE(8),
    .NMI_VECTOR(32'h0000_0080)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit reached, expected summary before it");
    $fatal(1, "bench timeout");
  end

  function automatic logic [31:0] chan_vec(input int k);
    return 32'h0000_0100 + 32'(k) * 32'd8;
  endfunction

  function automatic void push(input int id, input logic [31:0] vec);
    exp_t e;
    e.id  = 3'(id);
    e.vec = vec;
    sb.push_back(e);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Ticks until int_req (bounded), checks the latency, then compares against the scoreboard.
  task automatic wait_req(input string tag, input int exp_lat);
    int   n;
    exp_t e;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.int_req && n < 20);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    vectors++;
    assert (sb.size() != 0) else begin
      miscompares++;
      $error("FAIL %s_sb: got empty scoreboard, expected a queued request", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_req"}, 32'(bus.int_req), 32'd1);
      check({tag, "_id"}, 32'(bus.int_id), 32'(e.id));
      check({tag, "_vec"}, bus.int_vector, e.vec);
    end
  endtask

  task automatic do_ack();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic do_eoi();
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
  endtask

  task automatic write_mask(input logic [7:0] m);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = m;
    tick();
    bus.mask_we    = 1'b0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    bus.irq        = '0;
    bus.nmi        = 1'b0;
    bus.cpu_busy   = 1'b0;
    bus.int_ack    = 1'b0;
    bus.eoi        = 1'b0;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = '0;
    repeat (3) tick();
    check("rst_req", 32'(bus.int_req), 32'd0);
    check("rst_vec", bus.int_vector, 32'd0);
    check("rst_id", 32'(bus.int_id), 32'd0);
    check("rst_insvc", 32'(bus.in_service), 32'd0);
    check("rst_nmiact", 32'(bus.nmi_active), 32'd0);
    check("rst_mask", 32'(bus.mask), 32'h0000_00ff);
    rst = 1'b0;
    tick();

`ifdef IRQ_LEVEL_EN
    write_mask(8'h00);
    // irq[6] withdrawn before ack: back to idle, never serviced.
    bus.irq[6] = 1'b1;
    push(6, chan_vec(6));
    wait_req("lvl6", 1);
    bus.irq[6] = 1'b0;
    tick();
    check("lvl6_drop_req", 32'(bus.int_req), 32'd0);
    check("lvl6_drop_vec", bus.int_vector, 32'd0);
    tick();
    check("lvl6_no_req", 32'(bus.int_req), 32'd0);
    check("lvl6_no_svc", 32'(bus.in_service), 32'd0);
    // irq[2] held through service.
    bus.irq[2] = 1'b1;
    push(2, chan_vec(2));
    wait_req("lvl2", 1);
    do_ack();
    check("lvl2_svc", 32'(bus.in_service), 32'd1);
    check("lvl2_id", 32'(bus.int_id), 32'd2);
    bus.irq[2] = 1'b0;
    do_eoi();
    check("lvl2_eoi", 32'(bus.in_service), 32'd0);
    tick();
    check("lvl2_idle", 32'(bus.int_req), 32'd0);
    // NMI stays edge-sensitive even when held high.
    bus.nmi = 1'b1;
    push(0, 32'h0000_0080);
    wait_req("lvl_nmi", 2);
    do_ack();
    check("lvl_nmi_act", 32'(bus.nmi_active), 32'd1);
    do_eoi();
    check("lvl_nmi_done", 32'(bus.nmi_active), 32'd0);
    repeat (2) tick();
    check("lvl_nmi_held", 32'(bus.int_req), 32'd0);
    bus.nmi = 1'b0;
`else
    // Single pulse on irq[3]: presented two cycles after the pulse.
    write_mask(8'h00);
    check("mask0", 32'(bus.mask), 32'd0);
    bus.irq[3] = 1'b1;
    push(3, chan_vec(3));
    tick();
    bus.irq[3] = 1'b0;
    check("ch3_early", 32'(bus.int_req), 32'd0);
    wait_req("ch3", 1);
    do_ack();
    check("ch3_svc", 32'(bus.in_service), 32'd1);
    check("ch3_req_drop", 32'(bus.int_req), 32'd0);
    do_eoi();
    check("ch3_eoi_svc", 32'(bus.in_service), 32'd0);
    check("ch3_eoi_vec", bus.int_vector, 32'd0);
    check("ch3_eoi_id", 32'(bus.int_id), 32'd0);
    check("ch3_eoi_mask", 32'(bus.mask), 32'd0);

    // Simultaneous edges on 5 and 1: lower index first.
    bus.irq = 8'h22;
    push(1, chan_vec(1));
    push(5, chan_vec(5));
    tick();
    bus.irq = 8'h00;
    wait_req("pri1", 1);
    do_ack();
    do_eoi();
    wait_req("pri5", 1);
    do_ack();
    do_eoi();

    // Masked channel stays pending until unmasked.
    write_mask(8'h04);
    bus.irq[2] = 1'b1;
    tick();
    bus.irq[2] = 1'b0;
    repeat (3) tick();
    check("masked_no_req", 32'(bus.int_req), 32'd0);
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 8'h00;
    push(2, chan_vec(2));
    tick();
    bus.mask_we = 1'b0;
    wait_req("unmask2", 1);
    do_ack();
    do_eoi();

    // cpu_busy holds off the launch.
    bus.cpu_busy = 1'b1;
    bus.irq[0]   = 1'b1;
    tick();
    bus.irq[0] = 1'b0;
    repeat (10) tick();
    check("busy_no_req", 32'(bus.int_req), 32'd0);
    bus.cpu_busy = 1'b0;
    push(0, chan_vec(0));
    wait_req("busy0", 1);
    do_ack();
    do_eoi();

    // Stray ack/eoi in idle are ignored.
    bus.int_ack = 1'b1;
    bus.eoi     = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    bus.eoi     = 1'b0;
    check("stray_req", 32'(bus.int_req), 32'd0);
    check("stray_svc", 32'(bus.in_service), 32'd0);

    // NMI preempts the channel-4 handler, then service resumes.
    bus.irq[4] = 1'b1;
    push(4, chan_vec(4));
    tick();
    bus.irq[4] = 1'b0;
    wait_req("ch4", 1);
    do_ack();
    check("ch4_svc", 32'(bus.in_service), 32'd1);
    bus.nmi = 1'b1;
    push(0, 32'h0000_0080);
    tick();
    bus.nmi = 1'b0;
    wait_req("nmi4", 1);
    check("nmi4_svc_kept", 32'(bus.in_service), 32'd1);
    do_ack();
    check("nmi4_act", 32'(bus.nmi_active), 32'd1);
    check("nmi4_ack_svc", 32'(bus.in_service), 32'd1);
    do_eoi();
    check("nmi4_ret_vec", bus.int_vector, 32'h0000_0120);
    check("nmi4_ret_id", 32'(bus.int_id), 32'd4);
    check("nmi4_ret_act", 32'(bus.nmi_active), 32'd0);
    check("nmi4_ret_svc", 32'(bus.in_service), 32'd1);
    check("nmi4_ret_req", 32'(bus.int_req), 32'd0);
    do_eoi();
    check("ch4_done_svc", 32'(bus.in_service), 32'd0);
    check("ch4_done_vec", bus.int_vector, 32'd0);

    // Ack coincident with NMI edge: maskable acked, NMI follows from service.
    bus.irq[6] = 1'b1;
    push(6, chan_vec(6));
    tick();
    bus.irq[6] = 1'b0;
    wait_req("ch6", 1);
    bus.nmi     = 1'b1;
    bus.int_ack = 1'b1;
    push(0, 32'h0000_0080);
    tick();
    bus.nmi     = 1'b0;
    bus.int_ack = 1'b0;
    check("ch6_ack_svc", 32'(bus.in_service), 32'd1);
    check("ch6_ack_req", 32'(bus.int_req), 32'd0);
    wait_req("nmi6", 1);
    do_ack();
    do_eoi();
    check("nmi6_ret_vec", bus.int_vector, chan_vec(6));
    do_eoi();
    check("ch6_done", 32'(bus.in_service), 32'd0);

    // Reset mid-handshake drops the request and the pend latch.
    bus.irq[7] = 1'b1;
    push(7, chan_vec(7));
    tick();
    bus.irq[7] = 1'b0;
    wait_req("ch7", 1);
    rst         = 1'b1;
    bus.int_ack = 1'b1;
    tick();
    rst         = 1'b0;
    bus.int_ack = 1'b0;
    check("rst2_req", 32'(bus.int_req), 32'd0);
    check("rst2_svc", 32'(bus.in_service), 32'd0);
    check("rst2_mask", 32'(bus.mask), 32'h0000_00ff);
    write_mask(8'h00);
    repeat (3) tick();
    check("rst2_pend_gone", 32'(bus.int_req), 32'd0);
`endif

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
